// File: rtl/cm_guess_responder.sv
// Responder (MCU side) of the CM guessing protocol: generates CLK_inter, opens a session
// with BEGIN_GUESSING, receives START/guess/END frames and answers YES or NO.

module cm_bus_if (
  inout  wire  [7:0] CM,
  input  logic [7:0] data_out,
  input  logic       drive_en,
  output logic [7:0] data_in
);
  assign CM      = drive_en ? data_out : 8'hzz;
  assign data_in = CM;
endmodule

module cm_guess_responder #(
  parameter int HALF_PERIOD = 8,
  parameter int BEGIN_HOLD  = 4,
  parameter int TURNAROUND  = 6,
  parameter int LEAK_CYCLES = 0,
  parameter int REPLY_HOLD  = 4,
  parameter int HUNT_LIMIT  = 8
) (
  input  logic        CLK_50,
  input  logic        RST_N,
  input  logic        start,
  input  logic [7:0]  secret,
  output logic        CLK_inter,
  inout  wire  [7:0]  CM,
  output logic        busy,
  output logic        found,
  output logic [7:0]  found_byte,
  output logic [15:0] attempts,
  output logic        frame_err
);

  localparam logic [7:0] START_B = 8'h01;
  localparam logic [7:0] BEGIN_B = 8'h02;
  localparam logic [7:0] YES_B   = 8'h03;
  localparam logic [7:0] NO_B    = 8'h04;
  localparam logic [7:0] END_B   = 8'h05;

  localparam int PH_W = $clog2(HALF_PERIOD);
  localparam int PC_W = $clog2(HUNT_LIMIT + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_BEGIN,
    S_HUNT,
    S_GET_DATA,
    S_GET_END,
    S_TURN,
    S_REPLY,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            state_reg;
  logic [PH_W-1:0]   phase_cnt_reg;
  logic [PC_W-1:0]   pulse_cnt_reg;
  logic [15:0]       wait_cnt_reg;
  logic              clk_inter_reg;
  logic              drive_en_reg;
  logic [7:0]        data_out_reg;
  logic [7:0]        secret_reg;
  logic [7:0]        guess_reg;
  logic              reply_yes_reg;
  logic              busy_reg;
  logic              found_reg;
  logic [7:0]        found_byte_reg;
  logic [15:0]       attempts_reg;
  logic              frame_err_reg;

  logic [7:0]        data_in;
  logic              pulse_state;
  logic              phase_end;
  logic              sample_now;
  logic              leak_match;
  logic [15:0]       turn_len;

  cm_bus_if u_bus (
    .CM       (CM),
    .data_out (data_out_reg),
    .drive_en (drive_en_reg),
    .data_in  (data_in)
  );

  assign pulse_state = (state_reg == S_HUNT) || (state_reg == S_GET_DATA) ||
                       (state_reg == S_GET_END);
  assign phase_end   = (phase_cnt_reg == PH_W'(HALF_PERIOD - 1));
  // Last CLK_50 cycle of a high phase: the initiator has long since settled.
  assign sample_now  = pulse_state && clk_inter_reg && phase_end;
  assign leak_match  = (guess_reg[7:4] == secret_reg[7:4]);
  assign turn_len    = 16'(TURNAROUND) + (leak_match ? 16'(LEAK_CYCLES) : 16'd0);

  always_ff @(posedge CLK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= S_IDLE;
      phase_cnt_reg  <= '0;
      pulse_cnt_reg  <= '0;
      wait_cnt_reg   <= '0;
      clk_inter_reg  <= 1'b0;
      drive_en_reg   <= 1'b0;
      data_out_reg   <= 8'h00;
      secret_reg     <= 8'h00;
      guess_reg      <= 8'h00;
      reply_yes_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      found_reg      <= 1'b0;
      found_byte_reg <= 8'h00;
      attempts_reg   <= 16'h0000;
      frame_err_reg  <= 1'b0;
    end else begin
      if (pulse_state) begin
        if (phase_end) begin
          clk_inter_reg <= ~clk_inter_reg;
          phase_cnt_reg <= '0;
        end else begin
          phase_cnt_reg <= phase_cnt_reg + 1'b1;
        end
      end

      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          clk_inter_reg <= 1'b0;
          drive_en_reg  <= 1'b0;
          if (start) begin
            secret_reg     <= secret;
            attempts_reg   <= 16'h0000;
            found_reg      <= 1'b0;
            found_byte_reg <= 8'h00;
            frame_err_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            data_out_reg   <= BEGIN_B;
            drive_en_reg   <= 1'b1;
            wait_cnt_reg   <= '0;
            state_reg      <= S_BEGIN;
          end
        end

        S_BEGIN: begin
          if (wait_cnt_reg == 16'(BEGIN_HOLD - 1)) begin
            drive_en_reg  <= 1'b0;
            clk_inter_reg <= 1'b0;
            phase_cnt_reg <= '0;
            pulse_cnt_reg <= '0;
            state_reg     <= S_HUNT;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end

        S_HUNT: begin
          if (sample_now) begin
            if (data_in == START_B) begin
              state_reg <= S_GET_DATA;
            end else if (pulse_cnt_reg == PC_W'(HUNT_LIMIT - 1)) begin
              frame_err_reg <= 1'b1;
              busy_reg      <= 1'b0;
              state_reg     <= S_ERROR;
            end else begin
              pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
            end
          end
        end

        S_GET_DATA: begin
          if (sample_now) begin
            guess_reg <= data_in;
            state_reg <= S_GET_END;
          end
        end

        S_GET_END: begin
          if (sample_now) begin
            if (data_in == END_B) begin
              if (attempts_reg != 16'hFFFF) begin
                attempts_reg <= attempts_reg + 16'd1;
              end
              wait_cnt_reg <= '0;
              state_reg    <= S_TURN;
            end else begin
              frame_err_reg <= 1'b1;
              busy_reg      <= 1'b0;
              state_reg     <= S_ERROR;
            end
          end
        end

        // CLK_inter fell on entry; the bus stays quiet while the initiator lets go.
        S_TURN: begin
          if (wait_cnt_reg == turn_len - 16'd1) begin
            reply_yes_reg <= (guess_reg == secret_reg);
            data_out_reg  <= (guess_reg == secret_reg) ? YES_B : NO_B;
            drive_en_reg  <= 1'b1;
            wait_cnt_reg  <= '0;
            state_reg     <= S_REPLY;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end

        S_REPLY: begin
          if (wait_cnt_reg == 16'(REPLY_HOLD - 1)) begin
            drive_en_reg <= 1'b0;
            if (reply_yes_reg) begin
              found_reg      <= 1'b1;
              found_byte_reg <= guess_reg;
              busy_reg       <= 1'b0;
              state_reg      <= S_DONE;
            end else begin
              clk_inter_reg <= 1'b0;
              phase_cnt_reg <= '0;
              pulse_cnt_reg <= '0;
              state_reg     <= S_HUNT;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end

        default: begin
          drive_en_reg  <= 1'b0;
          clk_inter_reg <= 1'b0;
          busy_reg      <= 1'b0;
          state_reg     <= S_IDLE;
        end
      endcase
    end
  end

  assign CLK_inter  = clk_inter_reg;
  assign busy       = busy_reg;
  assign found      = found_reg;
  assign found_byte = found_byte_reg;
  assign attempts   = attempts_reg;
  assign frame_err  = frame_err_reg;

endmodule
